uart_rx_word: RTL and testbench



---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_rx_byte.sv | 187 ++++++++++++++++++
 rtl/uart_rx_word.sv | 134 +++++++++++++
 tb/tb_uart_rx_word.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART word receiver (and its transmit-side
// sibling): the receive FSM state encoding, default clocking constants, the
// counter widths derived from them and the number of bytes per word.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, the receive FSM gains a PARITY state (8E1 frames).
// ---------------------------------------------------------------------------
package uart_pkg;

  // Default clocking: 100 MHz PLL clock, 115200 baud.
  localparam int CLK_FREQ_DEF     = 100_000_000;
  localparam int BAUD_DEF         = 115_200;
  localparam int TIMEOUT_BITS_DEF = 20;

  // Clock cycles per bit period (integer division, 868 at the defaults).
  localparam int BAUD_DIV = CLK_FREQ_DEF / BAUD_DEF;

  // Bytes per assembled word; the transmitter uses the same constant.
  localparam int WORD_BYTES = 4;
  localparam int DATA_BITS  = 8;

  // Width of a counter that has to hold the values 0 .. n-1 (at least 1 bit).
  function automatic int cntWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Counter widths at the default clocking.
  localparam int BAUD_CNT_W = cntWidth(BAUD_DIV);
  localparam int GAP_CNT_W  = cntWidth(TIMEOUT_BITS_DEF * BAUD_DIV);
  localparam int BIT_CNT_W  = cntWidth(DATA_BITS);
  localparam int BYTE_CNT_W = cntWidth(WORD_BYTES);

  // Receive FSM states. PARITY only exists in the 8E1 build.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// Receives single UART bytes (8N1, or 8E1 with UART_RX_PARITY_EN defined).
// The asynchronous rx line goes through a 2-FF synchronizer and a third flop
// for falling-edge detection; a single FSM then samples every bit at its
// centre and reports the result with one-cycle pulses.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   rx_i         in   asynchronous UART line, idle high
//   byte_data_o  out  last received byte (valid while byte_done_o is high)
//   byte_done_o  out  one-cycle pulse: a good byte has been received
//   byte_err_o   out  one-cycle pulse: bad stop bit (or parity mismatch)
//   busy_o       out  high from start-bit detection until the byte ends
//
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after the data).
// ---------------------------------------------------------------------------
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int DIV = BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_data_o,
  output logic       byte_done_o,
  output logic       byte_err_o,
  output logic       busy_o
);

  localparam int CNT_W = cntWidth(DIV);
  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0]     FULL_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 prev_q;
  logic                 fall;

  rx_state_e            state_q;
  logic [CNT_W-1:0]     baud_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [7:0]           shift_q;
  logic                 done_q;
  logic                 err_q;
  logic                 busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err_q;
`endif

  // The synchronizer resets to 0 (line considered low), so no falling edge
  // can be seen until rx has actually been observed high after reset. A reset
  // taken while rx is low therefore waits for the line to go idle first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;

  // Receive FSM. START samples half a bit after the edge; every later bit is
  // sampled one full bit period after the previous sample, i.e. at its centre.
  // The stop bit is judged at its middle, so the FSM is back in IDLE half a
  // bit early and back-to-back frames are caught.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_q    <= ST_START;
            baud_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            if (!sync2_q) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end else begin
              // Line already back high at the start-bit centre: a glitch.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_cnt_q == FULL_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {sync2_q, shift_q[7:1]};
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_cnt_q == FULL_LAST) begin
            baud_cnt_q   <= '0;
            // Even parity: data plus parity bit must hold an even number of 1s.
            parity_err_q <= (^shift_q) ^ sync2_q;
            state_q      <= ST_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (baud_cnt_q == FULL_LAST) begin
            baud_cnt_q <= '0;
            busy_q     <= 1'b0;
            if (!sync2_q) begin
              err_q   <= 1'b1;
              state_q <= ST_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
            end else if (parity_err_q) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
`endif
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        ST_WAIT_IDLE: begin
          // A low stop bit may be a break or a misaligned frame; resync only
          // once the line is idle again.
          if (sync2_q) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_data_o = shift_q;
  assign byte_done_o = done_q;
  assign byte_err_o  = err_q;
  assign busy_o      = busy_q;

endmodule

// File: rtl/uart_rx_word.sv
// ---------------------------------------------------------------------------
// uart_rx_word
// Receives UART bytes and assembles each group of four consecutive good bytes
// into a 32-bit word, first byte in bits [31:24]. Partial words are never
// released: a framing error or an over-long gap between bytes drops them.
//
// Ports:
//   clk          in   system clock (100 MHz PLL domain)
//   rst_n        in   synchronous active-low reset
//   rx           in   asynchronous UART line, idle high
//   data_out     out  last complete word, held until the next word completes
//   data_valid   out  one-cycle pulse when data_out is updated
//   frame_err    out  one-cycle pulse on a bad stop bit (or parity error)
//   timeout_err  out  one-cycle pulse when a partial word is discarded
//   busy         out  high while a byte is being received
//
// Parameters: CLK_FREQ (Hz), BAUD (bit/s), TIMEOUT_BITS (max inter-byte gap
// in bit periods).
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames instead of 8N1).
// ---------------------------------------------------------------------------
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = CLK_FREQ_DEF,
  parameter int BAUD         = BAUD_DEF,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int DIV       = CLK_FREQ / BAUD;
  localparam int GAP_LIMIT = TIMEOUT_BITS * DIV;
  localparam int GAP_W     = cntWidth(GAP_LIMIT);
  localparam int STAGE_W   = (WORD_BYTES - 1) * 8;
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP_LIMIT - 1);
  localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(WORD_BYTES - 1);

  logic [7:0]            byte_data;
  logic                  byte_done;
  logic                  byte_err;
  logic                  rx_busy;

  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic [31:0]           data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  terr_q, terr_d;
  logic [GAP_W-1:0]      gap_q, gap_d;

  uart_rx_byte #(
    .DIV (DIV)
  ) u_rx_byte (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx),
    .byte_data_o (byte_data),
    .byte_done_o (byte_done),
    .byte_err_o  (byte_err),
    .busy_o      (rx_busy)
  );

  // Word assembly and inter-byte timeout. Earlier bytes of a word wait in a
  // staging register so data_out only ever changes on a complete word. The
  // gap counter runs only while the byte receiver is idle with a partial word
  // pending; any activity or an empty word keeps it at zero. When a start
  // edge coincides with the expiry, the expiry still clears byte_cnt, so the
  // new byte becomes byte 0 of a fresh word.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    stage_d    = stage_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    terr_d     = 1'b0;
    gap_d      = '0;

    if (byte_err) begin
      ferr_d     = 1'b1;
      byte_cnt_d = '0;
    end else if (byte_done) begin
      if (byte_cnt_q == BYTE_LAST) begin
        data_d     = {stage_q, byte_data};
        valid_d    = 1'b1;
        byte_cnt_d = '0;
      end else begin
        stage_d    = {stage_q[STAGE_W-9:0], byte_data};
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else if (!rx_busy && (byte_cnt_q != '0)) begin
      if (gap_q == GAP_LAST) begin
        terr_d     = 1'b1;
        byte_cnt_d = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  // State and registered output pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      stage_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      terr_q     <= 1'b0;
      gap_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      stage_q    <= stage_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      terr_q     <= terr_d;
      gap_q      <= gap_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;
  assign busy        = rx_busy;

endmodule

// File: tb/tb_uart_rx_word.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_word
// Scoreboard bench for uart_rx_word at a reduced bit period (16 clocks per
// bit) so every scenario fits in a few thousand cycles. Stimulus pushes the
// expected word/error events into a queue; a monitor pops and compares each
// time the DUT raises data_valid, frame_err or timeout_err.
// ---------------------------------------------------------------------------
module tb_uart_rx_word;

  localparam int CLK_FREQ     = 1_600_000;
  localparam int BAUD         = 100_000;
  localparam int TIMEOUT_BITS = 20;
  localparam int DIV          = CLK_FREQ / BAUD;

  typedef enum logic [1:0] {EV_WORD, EV_FRAME, EV_TIMEOUT} evKind_e;
  typedef struct packed {
    evKind_e     kind;
    logic [31:0] word;
  } expEvent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        timeout_err;
  logic        busy;

  expEvent_t   expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  logic        busySeen;

  uart_rx_word #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Compare one value and report a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectEvent(input evKind_e kind, input logic [31:0] word);
    expEvent_t e;
    e.kind = kind;
    e.word = word;
    expQ.push_back(e);
  endtask

  // Match one observed DUT event against the oldest expectation.
  task automatic popAndCheck(input evKind_e kind, input logic [31:0] word);
    expEvent_t e;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL unexpected event: got %s (data 0x%08h), expected none", kind.name(), word);
    end else begin
      e = expQ.pop_front();
      checkOutput("event kind", {30'b0, kind}, {30'b0, e.kind});
      if (kind == EV_WORD) checkOutput("word data", word, e.word);
    end
  endtask

  // Monitor: samples DUT outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid)  popAndCheck(EV_WORD, data_out);
      if (frame_err)   popAndCheck(EV_FRAME, 32'h0);
      if (timeout_err) popAndCheck(EV_TIMEOUT, 32'h0);
    end
  end

  // Hold one bit level on the line for a full bit period.
  task automatic driveBit(input logic b);
    @(negedge clk) rx = b;
    repeat (DIV - 1) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    @(negedge clk) rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  // One frame; a parity bit is inserted (correct even parity) in the 8E1 build.
  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
`ifdef UART_RX_PARITY_EN
    driveBit(^b);
`endif
    driveBit(stopBit);
    @(negedge clk) rx = 1'b1;
  endtask

  // Send a good word back to back, MSB byte first, and expect it.
  task automatic applyStimulus(input logic [31:0] word);
    expectEvent(EV_WORD, word);
    for (int i = 3; i >= 0; i--) sendByte(word[i*8 +: 8], 1'b1);
    idle(2 * DIV);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " data_out"}, data_out, 32'h0);
    checkOutput({tag, " data_valid"}, {31'b0, data_valid}, 32'h0);
    checkOutput({tag, " frame_err"}, {31'b0, frame_err}, 32'h0);
    checkOutput({tag, " timeout_err"}, {31'b0, timeout_err}, 32'h0);
    checkOutput({tag, " busy"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    logic [31:0] lastWord;

    // Reset with the line idle.
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    idle(10);

    // Four good bytes back to back.
    applyStimulus(32'h12345678);

    // Short low glitch: rejected at the start-bit centre, busy drops quickly.
    @(negedge clk) rx = 1'b0;
    busySeen = 1'b0;
    for (int i = 1; i <= DIV / 2 + 4; i++) begin
      @(negedge clk);
      if (i == DIV / 4) rx = 1'b1;
      if (busy) busySeen = 1'b1;
    end
    checkOutput("glitch busy raised", {31'b0, busySeen}, 32'h1);
    checkOutput("glitch busy released", {31'b0, busy}, 32'h0);
    idle(2 * DIV);
    applyStimulus(32'hDEADBEEF);

    // Stop bit low on the second byte: one frame error, word discarded.
    expectEvent(EV_FRAME, 32'h0);
    sendByte(8'h11, 1'b1);
    sendByte(8'h22, 1'b0);
    idle(2 * DIV);
    checkOutput("data_out held after frame error", data_out, 32'hDEADBEEF);
    applyStimulus(32'hA5A5A5A5);

    // Two bytes then a long gap: timeout, then a fresh full word.
    expectEvent(EV_TIMEOUT, 32'h0);
    sendByte(8'h11, 1'b1);
    sendByte(8'h22, 1'b1);
    idle(25 * DIV);
    applyStimulus(32'hCAFEBABE);

    // Reset in the middle of a data bit of byte 3 while the line is low.
    sendByte(8'h01, 1'b1);
    sendByte(8'h02, 1'b1);
    driveBit(1'b0);
    driveBit(1'b0);
    driveBit(1'b0);
    repeat (DIV / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("mid-byte reset");
    rst_n = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    checkOutput("busy while line low after reset", {31'b0, busy}, 32'h0);
    idle(2 * DIV);
    applyStimulus(32'h01020304);
    lastWord = 32'h01020304;

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: frame error, no word; then a correct word.
    expectEvent(EV_FRAME, 32'h0);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(i < 2);
    driveBit(1'b1);
    driveBit(1'b1);
    idle(2 * DIV);
    checkOutput("data_out held after parity error", data_out, 32'h01020304);
    applyStimulus(32'h03030303);
    lastWord = 32'h03030303;
`endif

    idle(4 * DIV);
    checkOutput("data_out holds last word", data_out, lastWord);

    // Any expectation never matched by a DUT event is a failure.
    while (expQ.size() > 0) begin
      expEvent_t e;
      e = expQ.pop_front();
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL missing event: got nothing, expected %s (data 0x%08h)", e.kind.name(), e.word);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
